// File: rtl/alu_mul_seq.sv
// Shift-add sequencer for unsigned 16x16->32 multiply on an external 16-bit ALU.
// Bit 0 is the MSB on every bus, so vectors are declared [0:15].
module alu_mul_seq (
  input  logic        clk_sys,
  input  logic        rst_,
  input  logic        start,
  input  logic [0:15] mcand,
  input  logic [0:15] mplier,
  output logic        busy,
  output logic        done,
  output logic [0:15] alu_a,
  output logic [0:15] alu_ac,
  output logic        saryt,
  output logic        sd_,
  output logic        sb_,
  output logic        sca_,
  output logic        saa_,
  output logic        scb_,
  output logic        sab_,
  output logic        p16_,
  input  logic [0:15] alu_f,
  input  logic        alu_carry_,
  output logic [0:15] prod_hi,
  output logic [0:15] prod_lo,
  output logic        ovf,
  output logic        zero
);

  localparam int ITER = 16;

  typedef enum logic [1:0] {S_IDLE, S_ITER, S_DONE} state_t;

  state_t      r_state;
  state_t      w_nextState;
  logic [0:15] r_mc;
  logic [0:15] r_hi;
  logic [0:15] r_lo;
  logic [3:0]  r_cnt;
  logic        r_ovf;
  logic        r_zero;

  logic        w_load;
  logic        w_add;
  logic        w_carry;
  logic        w_lastIter;
  logic [0:15] w_hiNext;
  logic [0:15] w_loNext;

  assign w_load     = start && (r_state == S_IDLE || r_state == S_DONE);
  assign w_add      = (r_state == S_ITER) && r_lo[15];
  assign w_carry    = w_add && !alu_carry_;
  assign w_lastIter = (r_cnt == 4'(ITER - 1));
  // The 17-bit {carry, sum} shifts right one place into the hi:lo pair.
  assign w_hiNext   = {w_carry, alu_f[0:14]};
  assign w_loNext   = {alu_f[15], r_lo[0:14]};

  assign alu_a   = r_hi;
  assign alu_ac  = r_mc;
  assign prod_hi = r_hi;
  assign prod_lo = r_lo;
  assign ovf     = r_ovf;
  assign zero    = r_zero;

  always_ff @(posedge clk_sys) begin
    if (!rst_) begin
      r_state <= S_IDLE;
      r_mc    <= '0;
      r_hi    <= '0;
      r_lo    <= '0;
      r_cnt   <= '0;
      r_ovf   <= 1'b0;
      r_zero  <= 1'b0;
    end else begin
      r_state <= w_nextState;
      if (w_load) begin
        r_mc   <= mcand;
        r_lo   <= mplier;
        r_hi   <= '0;
        r_cnt  <= '0;
        r_ovf  <= 1'b0;
        r_zero <= 1'b0;
      end else if (r_state == S_ITER) begin
        r_hi  <= w_hiNext;
        r_lo  <= w_loNext;
        r_cnt <= r_cnt + 4'd1;
        if (w_lastIter) begin
          r_ovf  <= |w_hiNext;
          r_zero <= ~|{w_hiNext, w_loNext};
        end
      end
    end
  end

  // Next state plus the active-low ALU function select; idle code by default.
  always_comb begin
    w_nextState = r_state;
    busy  = 1'b0;
    done  = 1'b0;
    saryt = 1'b0;
    sd_   = 1'b1;
    sb_   = 1'b1;
    sca_  = 1'b1;
    saa_  = 1'b1;
    scb_  = 1'b1;
    sab_  = 1'b1;
    p16_  = 1'b1;
    case (r_state)
      S_IDLE: begin
        if (start) w_nextState = S_ITER;
      end
      S_ITER: begin
        busy = 1'b1;
        if (w_lastIter) w_nextState = S_DONE;
        if (w_add) begin
          saryt = 1'b1;
          sd_   = 1'b0;
          saa_  = 1'b0;
          sab_  = 1'b0;
        end else begin
          sd_   = 1'b0;
          sb_   = 1'b0;
          sca_  = 1'b0;
          saa_  = 1'b0;
          scb_  = 1'b0;
          sab_  = 1'b0;
        end
      end
      S_DONE: begin
        done = 1'b1;
        w_nextState = start ? S_ITER : S_IDLE;
      end
      default: w_nextState = S_IDLE;
    endcase
  end

endmodule

// File: tb/tb_alu_mul_seq.sv
// Self-checking bench for alu_mul_seq: a behavioural ALU closes the loop and
// products are compared against plain 32-bit multiplication.
module tb_alu_mul_seq;

  logic        clk_sys = 1'b0;
  logic        rst_;
  logic        start;
  logic [0:15] mcand;
  logic [0:15] mplier;
  logic        busy;
  logic        done;
  logic [0:15] alu_a;
  logic [0:15] alu_ac;
  logic        saryt;
  logic        sd_;
  logic        sb_;
  logic        sca_;
  logic        saa_;
  logic        scb_;
  logic        sab_;
  logic        p16_;
  logic [0:15] alu_f;
  logic        alu_carry_;
  logic [0:15] prod_hi;
  logic [0:15] prod_lo;
  logic        ovf;
  logic        zero;

  int errors = 0;
  int checks = 0;

  localparam logic [7:0] IDLE_CODE = 8'b0111_1111;
  localparam logic [7:0] PASS_CODE = 8'b0000_0001;
  localparam logic [7:0] ADD_CODE  = 8'b1011_0101;

  logic [7:0]  ctrl;
  logic [31:0] prod;
  logic [16:0] aluSum;

  assign ctrl = {saryt, sd_, sb_, sca_, saa_, scb_, sab_, p16_};
  assign prod = {prod_hi, prod_lo};

  always #5 clk_sys = ~clk_sys;

  alu_mul_seq dut (
    .clk_sys(clk_sys), .rst_(rst_), .start(start), .mcand(mcand), .mplier(mplier),
    .busy(busy), .done(done), .alu_a(alu_a), .alu_ac(alu_ac), .saryt(saryt),
    .sd_(sd_), .sb_(sb_), .sca_(sca_), .saa_(saa_), .scb_(scb_), .sab_(sab_),
    .p16_(p16_), .alu_f(alu_f), .alu_carry_(alu_carry_), .prod_hi(prod_hi),
    .prod_lo(prod_lo), .ovf(ovf), .zero(zero)
  );

  // Behavioural ALU: full ADD code gives A+B with active-low carry, anything else passes A.
  always_comb begin
    aluSum     = {1'b0, alu_a} + {1'b0, alu_ac};
    alu_f      = alu_a;
    alu_carry_ = 1'b1;
    if (ctrl == ADD_CODE) begin
      alu_f      = aluSum[15:0];
      alu_carry_ = ~aluSum[16];
    end
  end

  task automatic startOp(input logic [15:0] a, input logic [15:0] b);
    @(negedge clk_sys);
    mcand  = a;
    mplier = b;
    start  = 1'b1;
    @(negedge clk_sys);
    start  = 1'b0;
  endtask

  task automatic waitDone(output int busyCycles);
    busyCycles = 0;
    while (busy && busyCycles < 40) begin
      busyCycles++;
      @(negedge clk_sys);
    end
  endtask

  task automatic test_reset;
    rst_ = 1'b0; start = 1'b0; mcand = '0; mplier = '0;
    repeat (2) @(negedge clk_sys);
    checks++;
    if ({busy, done, ovf, zero} !== 4'b0000) begin
      errors++; $display("[TB] FAIL reset_flags got=%b want=0000", {busy, done, ovf, zero});
    end
    checks++;
    if (prod !== 32'h0) begin
      errors++; $display("[TB] FAIL reset_prod got=%h want=00000000", prod);
    end
    checks++;
    if (ctrl !== IDLE_CODE) begin
      errors++; $display("[TB] FAIL reset_ctrl got=%b want=%b", ctrl, IDLE_CODE);
    end
    rst_ = 1'b1;
    @(negedge clk_sys);
    checks++;
    if ({busy, done, ctrl} !== {2'b00, IDLE_CODE}) begin
      errors++; $display("[TB] FAIL idle_hold got=%b want=%b", {busy, done, ctrl}, {2'b00, IDLE_CODE});
    end
  endtask

  // 3 x 5 with a per-cycle check that each multiplier bit, LSB first, picks ADD or PASS.
  task automatic test_basic;
    logic [15:0] b;
    b = 16'h0005;
    startOp(16'h0003, b);
    for (int k = 0; k < 16; k++) begin
      checks++;
      if (busy !== 1'b1 || done !== 1'b0) begin
        errors++; $display("[TB] FAIL basic_busy cycle=%0d got=%b%b want=10", k + 1, busy, done);
      end
      checks++;
      if (ctrl !== (b[k] ? ADD_CODE : PASS_CODE)) begin
        errors++; $display("[TB] FAIL basic_ctrl cycle=%0d got=%b want=%b", k + 1, ctrl, b[k] ? ADD_CODE : PASS_CODE);
      end
      @(negedge clk_sys);
    end
    checks++;
    if ({busy, done} !== 2'b01) begin
      errors++; $display("[TB] FAIL basic_done got=%b want=01", {busy, done});
    end
    checks++;
    if ({prod, ovf, zero} !== {32'h0000000F, 2'b00}) begin
      errors++; $display("[TB] FAIL basic_prod got=%h ovf=%b zero=%b want=0000000f 0 0", prod, ovf, zero);
    end
    checks++;
    if (ctrl !== IDLE_CODE) begin
      errors++; $display("[TB] FAIL basic_done_ctrl got=%b want=%b", ctrl, IDLE_CODE);
    end
    @(negedge clk_sys);
    checks++;
    if ({busy, done, prod} !== {2'b00, 32'h0000000F}) begin
      errors++; $display("[TB] FAIL basic_hold got=%b %h want=00 0000000f", {busy, done}, prod);
    end
  endtask

  task automatic test_max;
    int n;
    startOp(16'hFFFF, 16'hFFFF);
    waitDone(n);
    checks++;
    if (n !== 16 || done !== 1'b1) begin
      errors++; $display("[TB] FAIL max_latency got=%0d done=%b want=16 1", n, done);
    end
    checks++;
    if ({prod, ovf, zero} !== {32'hFFFE0001, 2'b10}) begin
      errors++; $display("[TB] FAIL max_prod got=%h ovf=%b zero=%b want=fffe0001 1 0", prod, ovf, zero);
    end
  endtask

  task automatic test_zero;
    int bad;
    bad = 0;
    startOp(16'h1234, 16'h0000);
    for (int k = 0; k < 16; k++) begin
      if (!busy || ctrl !== PASS_CODE) bad++;
      @(negedge clk_sys);
    end
    checks++;
    if (bad !== 0) begin
      errors++; $display("[TB] FAIL zero_pass_code got=%0d bad cycles want=0", bad);
    end
    checks++;
    if ({done, prod, ovf, zero} !== {1'b1, 32'h0, 2'b01}) begin
      errors++; $display("[TB] FAIL zero_prod got=%b %h ovf=%b zero=%b want=1 00000000 0 1", done, prod, ovf, zero);
    end
  endtask

  task automatic test_ignore_start;
    int n;
    startOp(16'h0100, 16'h0100);
    repeat (4) @(negedge clk_sys);
    mcand = 16'hABCD; mplier = 16'h1357; start = 1'b1;
    @(negedge clk_sys);
    start = 1'b0;
    waitDone(n);
    checks++;
    if (n !== 11 || done !== 1'b1) begin
      errors++; $display("[TB] FAIL ignore_latency got=%0d done=%b want=11 1", n, done);
    end
    checks++;
    if ({prod, ovf, zero} !== {32'h00010000, 2'b10}) begin
      errors++; $display("[TB] FAIL ignore_prod got=%h ovf=%b zero=%b want=00010000 1 0", prod, ovf, zero);
    end
  endtask

  task automatic test_mid_reset;
    int sawDone;
    sawDone = 0;
    startOp(16'h00FF, 16'h0002);
    repeat (7) @(negedge clk_sys);
    rst_ = 1'b0;
    @(negedge clk_sys);
    checks++;
    if ({busy, done, prod, ctrl} !== {2'b00, 32'h0, IDLE_CODE}) begin
      errors++; $display("[TB] FAIL midreset_state got=%b%b %h %b want=00 00000000 %b", busy, done, prod, ctrl, IDLE_CODE);
    end
    rst_ = 1'b1;
    repeat (20) begin
      if (done || busy) sawDone++;
      @(negedge clk_sys);
    end
    checks++;
    if (sawDone !== 0) begin
      errors++; $display("[TB] FAIL midreset_no_done got=%0d active cycles want=0", sawDone);
    end
  endtask

  task automatic test_back_to_back;
    int n;
    startOp(16'h0002, 16'h0002);
    waitDone(n);
    mcand = 16'h0007; mplier = 16'h0009; start = 1'b1;
    checks++;
    if ({done, prod} !== {1'b1, 32'h00000004}) begin
      errors++; $display("[TB] FAIL b2b_first got=%b %h want=1 00000004", done, prod);
    end
    @(negedge clk_sys);
    start = 1'b0;
    checks++;
    if ({busy, done} !== 2'b10) begin
      errors++; $display("[TB] FAIL b2b_restart got=%b want=10", {busy, done});
    end
    waitDone(n);
    checks++;
    if (n !== 16 || {done, prod} !== {1'b1, 32'h0000003F}) begin
      errors++; $display("[TB] FAIL b2b_second got=%0d %b %h want=16 1 0000003f", n, done, prod);
    end
  endtask

  task automatic test_random;
    int n;
    logic [15:0] a, b;
    logic [31:0] expProd;
    for (int t = 0; t < 12; t++) begin
      a = 16'($urandom);
      b = 16'($urandom);
      if (t == 0) a = 16'h8000;
      if (t == 1) b = 16'h0001;
      expProd = 32'(a) * 32'(b);
      startOp(a, b);
      mcand = ~a; mplier = ~b;
      waitDone(n);
      checks++;
      if (n !== 16 || done !== 1'b1 || prod !== expProd) begin
        errors++; $display("[TB] FAIL rand_prod %h*%h got=%0d %b %h want=16 1 %h", a, b, n, done, prod, expProd);
      end
      checks++;
      if ({ovf, zero} !== {expProd[31:16] != 16'h0, expProd == 32'h0}) begin
        errors++; $display("[TB] FAIL rand_flags %h*%h got=%b%b want=%b%b", a, b, ovf, zero, expProd[31:16] != 16'h0, expProd == 32'h0);
      end
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_max();
    test_zero();
    test_ignore_start();
    test_mid_reset();
    test_back_to_back();
    test_random();
    repeat (2) @(negedge clk_sys);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
